whiten_stage: RTL and testbench
===============================

WHITEN_STAGE -- requirements
Module: whiten_stage

Interface
REQ-001 SHALL have parameter N_SAMP, default 128, meaning samples per frame (power of two; LOG2 = 7).
REQ-002 SHALL have parameter W, default 26, meaning signed sample/coefficient width.
REQ-003 SHALL have parameter FRAC, default 22, meaning fractional bits of whitening coefficients.
REQ-004 SHALL have port clk_whiten, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-005 SHALL have port go_whiten, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, meaning a frame-start pulse.
REQ-007 SHALL have port x_valid, input, 1, meaning x1..x4 carry a raw sample this cycle.
REQ-008 SHALL have ports x1..x4, input, W signed each, meaning raw mixed-signal sample.
REQ-009 SHALL have ports v11..v44, input, W signed each (16 ports), meaning whitening matrix V.
REQ-010 SHALL have port whiten_busy, output, 1, meaning frame in progress.
REQ-011 SHALL have port go_fastica, output, 1, meaning active-low run/reset for the downstream FastICA stage.
REQ-012 SHALL have port z_valid, output, 1, meaning z1..z4 hold a whitened sample.
REQ-013 SHALL have ports z1..z4, output, W signed each, meaning whitened sample z = V*(x - mean).
REQ-014 SHALL have port done, output, 1, meaning a one-cycle pulse after the last z.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, MEAN, STREAM, DONE.
REQ-016 SHALL transition IDLE->LOAD on start; start SHALL be ignored in LOAD, MEAN and STREAM, and SHALL be accepted in DONE (DONE->LOAD).
REQ-017 In LOAD, SHALL write each x_valid sample to a 4 x N_SAMP buffer at wr_ptr, increment wr_ptr, and add the sample into four (W+7)-bit signed accumulators; gaps in x_valid SHALL be tolerated, and x_valid SHALL be ignored outside LOAD.
REQ-018 SHALL go LOAD->MEAN on the cycle the N_SAMP-th sample is written; wr_ptr SHALL wrap to 0.
REQ-019 MEAN SHALL last exactly 1 cycle: mean_i = acc_i >>> 7 (arithmetic shift, floor), and V SHALL be registered so V changes during STREAM have no effect.
REQ-020 STREAM SHALL issue read addresses 0..N_SAMP-1 on consecutive cycles through a 3-stage pipeline: (1) buffer read, (2) c_i = x_i - mean_i at W+1 bits, (3) z_r = sum_j v_rj*c_j at full width, >>> FRAC, saturated to W-bit signed.
REQ-021 First z_valid SHALL occur 3 cycles after STREAM entry, with exactly N_SAMP consecutive z_valid cycles and no bubbles.
REQ-022 go_fastica SHALL be low in IDLE, LOAD and MEAN and SHALL rise on the same edge as the first z_valid, remaining high through DONE until the next start.
REQ-023 done SHALL pulse 1 cycle on the edge after the last z_valid, entering DONE.
REQ-024 z1..z4 SHALL hold their last value when z_valid is low.
REQ-025 whiten_busy SHALL be high in LOAD, MEAN and STREAM.
REQ-026 start in DONE SHALL clear accumulators and wr_ptr and drive go_fastica low on the next edge.

Reset
REQ-027 go_whiten low SHALL asynchronously force state IDLE, zero all outputs (go_fastica=0, z_valid=0, done=0, whiten_busy=0, z=0), and zero wr_ptr, rd_ptr, accumulators and pipeline valids.
REQ-028 Buffer contents SHALL NOT be reset.
REQ-029 Reset mid-STREAM SHALL abort the frame with no further z_valid.

Structure
REQ-030 W, FRAC, N_SAMP, LOG2 and the FSM state encoding SHALL reside in shared package fastica_pkg.
REQ-031 The row dot-product-with-saturate SHALL be one sub-module, whiten_row, instantiated 4 times.

Verification
REQ-032 Bench SHALL check: start, 128 samples x=(1,2,3,4)<<22 with V=I (1<<22 diagonal) -> 128 z_valid, z=(0,0,0,0), go_fastica rising with the first z_valid, done 1 cycle after the last.
REQ-033 Bench SHALL check: x1 alternating +1.0/-1.0 (+/-4194304) with V=2I -> mean 0, z1 alternating +/-8388608.
REQ-034 Bench SHALL check: x_valid on every other cycle -> MEAN entered only after the 128th accepted sample, with output identical to the contiguous case.
REQ-035 Bench SHALL check: V=8I with x1 = +0x1FFFFFF in 64 samples and -0x2000000 in 64 -> z1 saturates to 0x1FFFFFF / 0x2000000.
REQ-036 Bench SHALL check: go_whiten low at STREAM cycle 50 -> outputs zero immediately, no further z_valid; a new start runs a clean frame.
REQ-037 Bench SHALL check: start asserted during LOAD -> ignored, sample count unaffected.

Source files
------------

// File: rtl/fastica_pkg.sv
// Shared constants and FSM encoding for the whitening / FastICA front end.
// Module parameters default to these values so the whole slice agrees on sizes.
package fastica_pkg;

   localparam int N_SAMP = 128;
   localparam int LOG2   = 7;
   localparam int W      = 26;
   localparam int FRAC   = 22;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_MEAN   = 3'd2,
      S_STREAM = 3'd3,
      S_DONE   = 3'd4
   } state_t;

endpackage

// File: rtl/whiten_row.sv
// One output row of the whitening product: z = sum_j v_j * c_j, scaled down by
// FRAC and clamped to the signed W-bit range.
module whiten_row #(
   parameter int W    = fastica_pkg::W,
   parameter int FRAC = fastica_pkg::FRAC
) (
   input  logic [3:0][W-1:0]   i_v,
   input  logic [3:0][W:0]     i_c,
   output logic signed [W-1:0] o_z
);

   localparam int PW = 2*W + 1;
   localparam int SW = PW + 2;

   logic signed [PW-1:0] w_prod [4];
   logic signed [SW-1:0] w_sum;
   logic signed [SW-1:0] w_sh;

   for (genvar j = 0; j < 4; j++) begin : g_mul
      assign w_prod[j] = $signed(i_v[j]) * $signed(i_c[j]);
   end

   assign w_sum = SW'(w_prod[0]) + SW'(w_prod[1]) + SW'(w_prod[2]) + SW'(w_prod[3]);
   assign w_sh  = w_sum >>> FRAC;

   // In range only when every bit above the W-bit sign position matches the sign.
   always_comb begin
      o_z = w_sh[W-1:0];
      if (w_sh[SW-1:W-1] != {(SW-W+1){w_sh[SW-1]}}) begin
         o_z = w_sh[SW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      end
   end

endmodule

// File: rtl/whiten_stage.sv
// Whitening stage: buffers one frame of 4-channel samples, removes the per-channel
// mean, and streams z = V*(x - mean) to the FastICA stage.
module whiten_stage
   import fastica_pkg::*;
#(
   parameter int N_SAMP = fastica_pkg::N_SAMP,
   parameter int W      = fastica_pkg::W,
   parameter int FRAC   = fastica_pkg::FRAC
) (
   input  logic                clk_whiten,
   input  logic                go_whiten,
   input  logic                start,
   input  logic                x_valid,
   input  logic signed [W-1:0] x1,
   input  logic signed [W-1:0] x2,
   input  logic signed [W-1:0] x3,
   input  logic signed [W-1:0] x4,
   input  logic signed [W-1:0] v11,
   input  logic signed [W-1:0] v12,
   input  logic signed [W-1:0] v13,
   input  logic signed [W-1:0] v14,
   input  logic signed [W-1:0] v21,
   input  logic signed [W-1:0] v22,
   input  logic signed [W-1:0] v23,
   input  logic signed [W-1:0] v24,
   input  logic signed [W-1:0] v31,
   input  logic signed [W-1:0] v32,
   input  logic signed [W-1:0] v33,
   input  logic signed [W-1:0] v34,
   input  logic signed [W-1:0] v41,
   input  logic signed [W-1:0] v42,
   input  logic signed [W-1:0] v43,
   input  logic signed [W-1:0] v44,
   output logic                whiten_busy,
   output logic                go_fastica,
   output logic                z_valid,
   output logic signed [W-1:0] z1,
   output logic signed [W-1:0] z2,
   output logic signed [W-1:0] z3,
   output logic signed [W-1:0] z4,
   output logic                done
);

   localparam int LG = $clog2(N_SAMP);
   localparam int AW = W + LG;

   logic [3:0][W-1:0]       w_x;
   logic [3:0][3:0][W-1:0]  w_v;
   logic [3:0][W-1:0]       w_z;
   logic                    w_issue;

   state_t                  r_state;
   logic [LG-1:0]           r_wr_ptr;
   logic [LG-1:0]           r_rd_ptr;
   logic                    r_rd_last;
   logic [3:0][AW-1:0]      r_acc;
   logic [3:0][W-1:0]       r_mean;
   logic [3:0][3:0][W-1:0]  r_v;
   logic [3:1]              r_vld_pipe;
   logic [3:0][W-1:0]       r_z;
   logic                    r_go;
   logic                    r_done;
   logic                    r_busy;

   logic [3:0][W-1:0]       r_buf [N_SAMP];
   logic [3:0][W-1:0]       r_rd;
   logic [3:0][W:0]         r_c;

   assign w_x = {x4, x3, x2, x1};
   assign w_v = {{v44, v43, v42, v41},
                 {v34, v33, v32, v31},
                 {v24, v23, v22, v21},
                 {v14, v13, v12, v11}};

   assign w_issue = (r_state == S_STREAM) && !r_rd_last;

   // Sample buffer and pipeline datapath carry no reset; only valids are reset.
   always_ff @(posedge clk_whiten) begin
      if (r_state == S_LOAD && x_valid) begin
         r_buf[r_wr_ptr] <= w_x;
      end
      r_rd <= r_buf[r_rd_ptr];
      for (int i = 0; i < 4; i++) begin
         r_c[i] <= (W+1)'($signed(r_rd[i])) - (W+1)'($signed(r_mean[i]));
      end
   end

   for (genvar r = 0; r < 4; r++) begin : g_row
      whiten_row #(.W(W), .FRAC(FRAC)) u_row (
         .i_v (r_v[r]),
         .i_c (r_c),
         .o_z (w_z[r])
      );
   end

   always_ff @(posedge clk_whiten or negedge go_whiten) begin
      if (!go_whiten) begin
         r_state    <= S_IDLE;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_rd_last  <= 1'b0;
         r_acc      <= '0;
         r_mean     <= '0;
         r_v        <= '0;
         r_vld_pipe <= '0;
         r_z        <= '0;
         r_go       <= 1'b0;
         r_done     <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_done     <= 1'b0;
         r_vld_pipe <= {r_vld_pipe[2:1], w_issue};
         if (r_vld_pipe[2]) begin
            r_z <= w_z;
         end
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_state  <= S_LOAD;
                  r_wr_ptr <= '0;
                  r_acc    <= '0;
                  r_go     <= 1'b0;
                  r_busy   <= 1'b1;
               end
            end
            S_LOAD: begin
               if (x_valid) begin
                  for (int i = 0; i < 4; i++) begin
                     r_acc[i] <= r_acc[i] + AW'($signed(w_x[i]));
                  end
                  r_wr_ptr <= r_wr_ptr + 1'b1;
                  if (r_wr_ptr == LG'(N_SAMP - 1)) begin
                     r_state <= S_MEAN;
                  end
               end
            end
            S_MEAN: begin
               for (int i = 0; i < 4; i++) begin
                  r_mean[i] <= W'($signed(r_acc[i]) >>> LG);
               end
               r_v       <= w_v;
               r_rd_ptr  <= '0;
               r_rd_last <= 1'b0;
               r_state   <= S_STREAM;
            end
            S_STREAM: begin
               if (w_issue) begin
                  r_rd_ptr <= r_rd_ptr + 1'b1;
                  if (r_rd_ptr == LG'(N_SAMP - 1)) begin
                     r_rd_last <= 1'b1;
                  end
               end
               if (r_vld_pipe[2]) begin
                  r_go <= 1'b1;
               end
               // Last z has just been presented and nothing is behind it.
               if (r_vld_pipe[3] && !r_vld_pipe[2] && r_rd_last) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign whiten_busy = r_busy;
   assign go_fastica  = r_go;
   assign z_valid     = r_vld_pipe[3];
   assign done        = r_done;
   assign z1          = r_z[0];
   assign z2          = r_z[1];
   assign z3          = r_z[2];
   assign z4          = r_z[3];

endmodule

// File: tb/tb_whiten_stage.sv
// Directed/randomized bench for whiten_stage against a plain-arithmetic model of
// mean removal, matrix product, scaling and saturation.
module tb_whiten_stage;

   localparam int N    = 128;
   localparam int W    = 26;
   localparam int FRAC = 22;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, start, x_valid;
   logic signed [W-1:0] x1, x2, x3, x4;
   logic [15:0][W-1:0]  vbus;
   logic busy, gof, zv, done;
   logic signed [W-1:0] z1, z2, z3, z4;

   int n_cmp  = 0;
   int n_fail = 0;

   logic signed [W-1:0] sx [N][4];
   logic signed [W-1:0] sv [4][4];
   logic [4*W-1:0]      exp_z [N];

   whiten_stage dut (
      .clk_whiten (clk),    .go_whiten (rst_n),   .start (start),   .x_valid (x_valid),
      .x1 (x1), .x2 (x2), .x3 (x3), .x4 (x4),
      .v11 (vbus[0]),  .v12 (vbus[1]),  .v13 (vbus[2]),  .v14 (vbus[3]),
      .v21 (vbus[4]),  .v22 (vbus[5]),  .v23 (vbus[6]),  .v24 (vbus[7]),
      .v31 (vbus[8]),  .v32 (vbus[9]),  .v33 (vbus[10]), .v34 (vbus[11]),
      .v41 (vbus[12]), .v42 (vbus[13]), .v43 (vbus[14]), .v44 (vbus[15]),
      .whiten_busy (busy), .go_fastica (gof), .z_valid (zv),
      .z1 (z1), .z2 (z2), .z3 (z3), .z4 (z4), .done (done)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic longint fdiv(input longint a, input longint d);
      longint q;
      q = a / d;
      if ((a % d != 0) && (a < 0)) q -= 1;
      return q;
   endfunction

   // Reference: floor mean per channel, then z_r = sat(floor(sum_j v_rj*(x_j-mean_j) / 2^FRAC)).
   task automatic build_model();
      longint acc, s;
      longint mean [4];
      for (int i = 0; i < 4; i++) begin
         acc = 0;
         for (int k = 0; k < N; k++) acc += longint'(sx[k][i]);
         mean[i] = fdiv(acc, N);
      end
      for (int k = 0; k < N; k++) begin
         for (int r = 0; r < 4; r++) begin
            s = 0;
            for (int j = 0; j < 4; j++) s += longint'(sv[r][j]) * (longint'(sx[k][j]) - mean[j]);
            s = fdiv(s, longint'(1) << FRAC);
            if (s > (longint'(1) << (W-1)) - 1) s = (longint'(1) << (W-1)) - 1;
            if (s < -(longint'(1) << (W-1)))    s = -(longint'(1) << (W-1));
            exp_z[k][r*W +: W] = W'(s);
         end
      end
   endtask

   task automatic drive_v();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) vbus[r*4+c] = sv[r][c];
   endtask

   task automatic set_v_diag(input logic signed [W-1:0] d);
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) sv[r][c] = (r == c) ? d : '0;
   endtask

   task automatic rand_x();
      for (int k = 0; k < N; k++)
         for (int i = 0; i < 4; i++) sx[k][i] = W'($urandom);
   endtask

   task automatic rand_v();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) sv[r][c] = W'(int'($urandom_range(0, 16777216)) - 8388608);
   endtask

   task automatic run_frame(input string tag, input bit gaps, input bit start_mid,
                            input bit v_scramble, input int abort_at);
      int acc_cnt, t, nz, first_t;
      bit fin;
      build_model();
      drive_v();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      chk({tag, "/load_flags"}, {busy, gof, zv, done}, 4'b1000);
      acc_cnt = 0;
      t = 0;
      while (acc_cnt < N) begin
         x_valid = gaps ? (t % 2 == 0) : 1'b1;
         if (x_valid) begin
            x1 = sx[acc_cnt][0]; x2 = sx[acc_cnt][1]; x3 = sx[acc_cnt][2]; x4 = sx[acc_cnt][3];
         end else begin
            x1 = W'($urandom); x2 = W'($urandom); x3 = W'($urandom); x4 = W'($urandom);
         end
         start = start_mid && (acc_cnt >= 20) && (acc_cnt < 23);
         @(negedge clk);
         if (x_valid) acc_cnt++;
         t++;
         if (acc_cnt < N) chk({tag, "/loading"}, {busy, gof, zv, done}, 4'b1000);
      end
      x_valid = 1'b0;
      start   = 1'b0;
      chk({tag, "/mean"}, {busy, gof, zv, done}, 4'b1000);
      nz = 0;
      first_t = -1;
      fin = 1'b0;
      for (int c = 1; c <= N + 40; c++) begin
         @(negedge clk);
         if (v_scramble && c == 2) for (int i = 0; i < 16; i++) vbus[i] = W'($urandom);
         if (first_t < 0 && !zv) chk({tag, "/gof_low_pre_z"}, gof, 1'b0);
         if (zv) begin
            if (first_t < 0) begin
               first_t = c;
               chk({tag, "/first_z_latency"}, c, 4);
               chk({tag, "/gof_rise"}, gof, 1'b1);
            end
            if (nz < N) chk({tag, "/z"}, {z4, z3, z2, z1}, exp_z[nz]);
            nz++;
            if (nz == abort_at) begin
               rst_n = 1'b0;
               #1;
               chk({tag, "/abort_outputs"}, {busy, gof, zv, done, z4, z3, z2, z1}, '0);
               repeat (8) begin
                  @(negedge clk);
                  chk({tag, "/abort_quiet"}, {busy, gof, zv, done}, 4'b0000);
               end
               rst_n = 1'b1;
               fin = 1'b1;
               break;
            end
         end
         if (done) begin
            chk({tag, "/done_timing"}, c, first_t + N);
            chk({tag, "/z_count"}, nz, N);
            chk({tag, "/done_flags"}, {busy, gof, zv}, 3'b010);
            chk({tag, "/z_hold"}, {z4, z3, z2, z1}, exp_z[N-1]);
            @(negedge clk);
            chk({tag, "/post_done"}, {busy, gof, zv, done}, 4'b0100);
            chk({tag, "/z_hold2"}, {z4, z3, z2, z1}, exp_z[N-1]);
            fin = 1'b1;
            break;
         end
      end
      if (!fin) chk({tag, "/timeout"}, 1'b0, 1'b1);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; x_valid = 1'b0;
      x1 = '0; x2 = '0; x3 = '0; x4 = '0;
      vbus = '0;
      #1;
      chk("reset", {busy, gof, zv, done, z4, z3, z2, z1}, '0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Constant input, identity V: mean equals the sample, z is zero.
      for (int k = 0; k < N; k++) begin
         sx[k][0] = W'(1 << 22); sx[k][1] = W'(2 << 22); sx[k][2] = W'(3 << 22); sx[k][3] = W'(4 << 22);
      end
      set_v_diag(W'(1 << 22));
      run_frame("ident", 1'b0, 1'b0, 1'b0, -1);

      // x1 alternating +/-1.0 with V = 2I.
      rand_x();
      for (int k = 0; k < N; k++) sx[k][0] = (k % 2 == 0) ? W'(4194304) : W'(-4194304);
      set_v_diag(W'(2 << 22));
      run_frame("alt_2I", 1'b0, 1'b0, 1'b0, -1);

      // Random data/matrix contiguous, then the same frame with gaps and V changed mid-stream.
      rand_x();
      rand_v();
      run_frame("rand_contig", 1'b0, 1'b0, 1'b0, -1);
      run_frame("rand_gaps", 1'b1, 1'b0, 1'b1, -1);

      // V = 8I: the 8.0 diagonal wraps to -8.0 in W bits, so z1 clips at both rails.
      rand_x();
      for (int k = 0; k < N; k++) sx[k][0] = (k < N/2) ? W'(26'h1FFFFFF) : W'(26'h2000000);
      set_v_diag(W'(8 << 22));
      run_frame("saturate", 1'b0, 1'b0, 1'b0, -1);

      rand_x();
      rand_v();
      run_frame("start_in_load", 1'b0, 1'b1, 1'b0, -1);

      rand_x();
      run_frame("abort", 1'b0, 1'b0, 1'b0, 50);
      rand_x();
      rand_v();
      run_frame("after_abort", 1'b0, 1'b0, 1'b0, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
